// File: rtl/vga_mem_port.sv
// Serves VGA pixel-pair reads from ZBT SRAM (front buffer) ahead of back-buffer writes; 4-cycle read return at RD_LAT=2.
// No backpressure on VGA; a write waits un-acked while VGA owns the slot and may re-request the cycle after its ack.
module vga_mem_port #(
    parameter int                  LOG_MEM      = 36,
    parameter int                  LOG_ADDR     = 19,
    parameter int                  LOG_HCOUNT   = 10,
    parameter int                  LOG_VCOUNT   = 10,
    parameter int                  HWORDS       = 320,
    parameter logic [LOG_ADDR-1:0] FRAME_OFFSET = 19'h40000,
    parameter int                  RD_LAT       = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] vga_hcount,
    input  logic [LOG_VCOUNT-1:0] vga_vcount,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    input  logic                  wr_req,
    input  logic [LOG_ADDR-1:0]   wr_addr,
    input  logic [LOG_MEM-1:0]    wr_data,
    output logic                  wr_ack,
    output logic [LOG_ADDR-1:0]   mem_addr,
    output logic                  mem_we,
    output logic [LOG_MEM-1:0]    mem_dout,
    output logic                  mem_oe,
    input  logic [LOG_MEM-1:0]    mem_din,
    output logic                  front_buf
);

    logic [LOG_ADDR-1:0]   mem_addr_q, mem_addr_d;
    logic                  front_q, front_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  wr_ack_q;
    logic [RD_LAT:0]       we_pipe_q;
    logic [LOG_MEM-1:0]    wdat_q [RD_LAT+1];
    logic [RD_LAT:0]       tag_vld_q;
    logic [RD_LAT:0]       tag_real_q;
    logic                  done_q;
    logic [LOG_MEM-1:0]    pixel_q;

    logic                  in_range;
    logic                  rd_real;
    logic                  swap_hit;
    logic                  wr_go;
    logic [LOG_HCOUNT-1:0] h_word;
    logic [LOG_ADDR-1:0]   v_ext;
    logic [LOG_ADDR-1:0]   h_ext;
    logic [LOG_ADDR-1:0]   rd_addr;
    logic [LOG_ADDR-1:0]   wr_full_addr;

    assign in_range = (vga_vcount < LOG_VCOUNT'(480)) && (vga_hcount < LOG_HCOUNT'(2 * HWORDS));
    assign rd_real  = vga_flag && in_range;
    assign h_word   = vga_hcount >> 1;
    assign v_ext    = LOG_ADDR'(vga_vcount);
    assign h_ext    = LOG_ADDR'(h_word);

    // The swap-point request itself must already read from the new front buffer.
    assign swap_hit = rd_real && swap_pending_q && (vga_vcount == '0) && (h_word == '0);
    // A write is not re-sampled in its own ack cycle, so a held wr_req is not issued twice.
    assign wr_go    = wr_req && !wr_ack_q && !rd_real;

    assign rd_addr      = (front_d ? FRAME_OFFSET : '0) + (v_ext << 8) + (v_ext << 6) + h_ext;
    assign wr_full_addr = (front_q ? '0 : FRAME_OFFSET) + wr_addr;

    always_comb begin
        front_d        = front_q ^ swap_hit;
        swap_pending_d = swap_hit ? frame_flag : (swap_pending_q | frame_flag);
        mem_addr_d     = mem_addr_q;
        if (rd_real) begin
            mem_addr_d = rd_addr;
        end else if (wr_go) begin
            mem_addr_d = wr_full_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q     <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_ack_q       <= 1'b0;
            we_pipe_q      <= '0;
            tag_vld_q      <= '0;
            tag_real_q     <= '0;
            done_q         <= 1'b0;
            pixel_q        <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                wdat_q[i] <= '0;
            end
        end else begin
            mem_addr_q     <= mem_addr_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            wr_ack_q       <= wr_go;
            we_pipe_q      <= {we_pipe_q[RD_LAT-1:0], wr_go};
            tag_vld_q      <= {tag_vld_q[RD_LAT-1:0], vga_flag};
            tag_real_q     <= {tag_real_q[RD_LAT-1:0], rd_real};
            wdat_q[0]      <= wr_go ? wr_data : wdat_q[0];
            for (int i = 1; i <= RD_LAT; i++) begin
                wdat_q[i] <= wdat_q[i-1];
            end
            // Last tag stage lines up with the cycle mem_din carries the read data.
            done_q <= tag_vld_q[RD_LAT];
            if (tag_vld_q[RD_LAT]) begin
                pixel_q <= tag_real_q[RD_LAT] ? mem_din : '0;
            end
        end
    end

    assign vga_pixel = pixel_q;
    assign done_vga  = done_q;
    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = we_pipe_q[0];
    assign mem_oe    = we_pipe_q[RD_LAT];
    assign mem_dout  = wdat_q[RD_LAT];
    assign front_buf = front_q;

endmodule

// File: tb/tb_vga_mem_port.sv
// Directed bench for vga_mem_port: read timing, write arbitration, out-of-range reads, buffer swap, reset.
module tb_vga_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic        vga_flag;
    logic [9:0]  vga_hcount;
    logic [9:0]  vga_vcount;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        wr_ack;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_dout;
    logic        mem_oe;
    logic [35:0] mem_din;
    logic        front_buf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [35:0] exp_pix [4] = '{36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444};

    vga_mem_port dut (
        .clock      (clock),
        .reset      (reset),
        .frame_flag (frame_flag),
        .vga_flag   (vga_flag),
        .vga_hcount (vga_hcount),
        .vga_vcount (vga_vcount),
        .vga_pixel  (vga_pixel),
        .done_vga   (done_vga),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .mem_oe     (mem_oe),
        .mem_din    (mem_din),
        .front_buf  (front_buf)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rd(input int v, input int h);
        vga_flag   = 1'b1;
        vga_vcount = 10'(v);
        vga_hcount = 10'(h);
    endtask

    initial begin
        reset = 1'b1; frame_flag = 1'b0; vga_flag = 1'b0; vga_hcount = '0; vga_vcount = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_din = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_pixel", 64'(vga_pixel), 64'h0);
        chk("rst_done", 64'(done_vga), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_we", 64'(mem_we), 64'h0);
        chk("rst_oe", 64'(mem_oe), 64'h0);
        chk("rst_front", 64'(front_buf), 64'h0);

        // Single read v=1 h=5
        rd(1, 5);
        tick(); vga_flag = 1'b0;
        chk("t1_addr", 64'(mem_addr), 64'd322);
        chk("t1_we", 64'(mem_we), 64'h0);
        tick();
        tick(); mem_din = 36'h123456789;
        chk("t1_done_early", 64'(done_vga), 64'h0);
        tick();
        chk("t1_done", 64'(done_vga), 64'h1);
        chk("t1_pixel", 64'(vga_pixel), 64'h123456789);
        mem_din = '0;
        tick();
        chk("t1_done_pulse", 64'(done_vga), 64'h0);
        chk("t1_pixel_hold", 64'(vga_pixel), 64'h123456789);

        // Read and write in same cycle: read wins, write next cycle
        rd(0, 2);
        wr_req = 1'b1; wr_addr = 19'd7; wr_data = 36'hABCDE0123;
        tick(); vga_flag = 1'b0;
        chk("t2_rd_addr", 64'(mem_addr), 64'd1);
        chk("t2_rd_we", 64'(mem_we), 64'h0);
        chk("t2_ack_stall", 64'(wr_ack), 64'h0);
        tick();
        chk("t2_wr_addr", 64'(mem_addr), 64'h40007);
        chk("t2_wr_we", 64'(mem_we), 64'h1);
        chk("t2_ack", 64'(wr_ack), 64'h1);
        tick(); wr_req = 1'b0; mem_din = 36'h0000000AA;
        chk("t2_no_rewrite", 64'(mem_we), 64'h0);
        chk("t2_ack_pulse", 64'(wr_ack), 64'h0);
        chk("t2_oe_early", 64'(mem_oe), 64'h0);
        chk("t2_addr_hold", 64'(mem_addr), 64'h40007);
        tick(); mem_din = '0;
        chk("t2_oe", 64'(mem_oe), 64'h1);
        chk("t2_dout", 64'(mem_dout), 64'hABCDE0123);
        chk("t2_rd_done", 64'(done_vga), 64'h1);
        chk("t2_rd_pixel", 64'(vga_pixel), 64'h0000000AA);
        tick();
        chk("t2_oe_pulse", 64'(mem_oe), 64'h0);

        // Back-to-back reads h=0,2,4,6
        for (int i = 0; i < 8; i++) begin
            vga_flag   = (i < 4);
            vga_vcount = '0;
            vga_hcount = 10'(2 * i);
            mem_din    = '0;
            if (i >= 3 && i <= 6) mem_din = exp_pix[i-3];
            tick();
            if (i < 4) chk("t3_addr", 64'(mem_addr), 64'(i));
            if (i >= 3 && i <= 6) begin
                chk("t3_done", 64'(done_vga), 64'h1);
                chk("t3_pixel", 64'(vga_pixel), 64'(exp_pix[i-3]));
            end else begin
                chk("t3_idle", 64'(done_vga), 64'h0);
            end
        end

        // Out-of-range read gives its slot to a pending write and returns zero
        rd(500, 0);
        wr_req = 1'b1; wr_addr = 19'd3; wr_data = 36'h5A5A5A5A5;
        tick(); vga_flag = 1'b0;
        chk("t4_wr_we", 64'(mem_we), 64'h1);
        chk("t4_wr_addr", 64'(mem_addr), 64'h40003);
        chk("t4_ack", 64'(wr_ack), 64'h1);
        wr_req = 1'b0;
        tick();
        tick(); mem_din = 36'hFFFFFFFFF;
        chk("t4_oe", 64'(mem_oe), 64'h1);
        chk("t4_dout", 64'(mem_dout), 64'h5A5A5A5A5);
        tick();
        chk("t4_done", 64'(done_vga), 64'h1);
        chk("t4_zero_pixel", 64'(vga_pixel), 64'h0);

        // Buffer swap
        mem_din = 36'h0DEADBEEF;
        frame_flag = 1'b1;
        tick(); frame_flag = 1'b0;
        rd(3, 0);
        tick();
        chk("t5_pre_addr", 64'(mem_addr), 64'd960);
        chk("t5_pre_front", 64'(front_buf), 64'h0);
        rd(0, 1);
        tick(); vga_flag = 1'b0;
        chk("t5_swap_addr", 64'(mem_addr), 64'h40000);
        chk("t5_swap_front", 64'(front_buf), 64'h1);
        wr_req = 1'b1; wr_addr = 19'd5; wr_data = 36'h987654321;
        tick(); wr_req = 1'b0;
        chk("t5_back_addr", 64'(mem_addr), 64'd5);
        chk("t5_back_ack", 64'(wr_ack), 64'h1);
        rd(0, 0);
        tick(); vga_flag = 1'b0;
        chk("t5_no_reswap_addr", 64'(mem_addr), 64'h40000);
        chk("t5_no_reswap_front", 64'(front_buf), 64'h1);
        frame_flag = 1'b1;
        tick();
        rd(0, 0);
        tick(); frame_flag = 1'b0;
        chk("t5_swap2_addr", 64'(mem_addr), 64'h0);
        chk("t5_swap2_front", 64'(front_buf), 64'h0);
        tick();
        chk("t5_swap3_addr", 64'(mem_addr), 64'h40000);
        chk("t5_swap3_front", 64'(front_buf), 64'h1);
        tick(); vga_flag = 1'b0;
        chk("t5_settled_front", 64'(front_buf), 64'h1);

        // Reset mid-operation
        for (int i = 0; i < 6; i++) tick();
        chk("t6_pre_pixel", 64'(vga_pixel), 64'h0DEADBEEF);
        rd(1, 0);
        tick(); vga_flag = 1'b0; reset = 1'b1;
        chk("t6_pre_addr", 64'(mem_addr), 64'h40140);
        tick(); reset = 1'b0;
        chk("t6_pixel", 64'(vga_pixel), 64'h0);
        chk("t6_done", 64'(done_vga), 64'h0);
        chk("t6_ack", 64'(wr_ack), 64'h0);
        chk("t6_addr", 64'(mem_addr), 64'h0);
        chk("t6_we", 64'(mem_we), 64'h0);
        chk("t6_dout", 64'(mem_dout), 64'h0);
        chk("t6_oe", 64'(mem_oe), 64'h0);
        chk("t6_front", 64'(front_buf), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_done", 64'(done_vga), 64'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_mem_port.md
# vga_mem_port

Memory-side port that serves the VGA output stage's pixel-pair fetches from ZBT SRAM and arbitrates them against a lower-priority frame-buffer write client. Each VGA request is turned into a read of one 36-bit word, which holds two 18-bit YCrCb pixels, from the current front buffer; the word is returned with a `done_vga` pulse. Two frame buffers are ping-ponged on `frame_flag`, and writes always target the back buffer.

## Interface
Parameters:
- `LOG_MEM`, 36: memory word width (two pixels).
- `LOG_ADDR`, 19: SRAM address width.
- `LOG_HCOUNT`, 10: hcount width.
- `LOG_VCOUNT`, 10: vcount width.
- `HWORDS`, 320: words per line (640 pixels / 2).
- `FRAME_OFFSET`, 19'h40000: base address of buffer 1; buffer 0 is at 0.
- `RD_LAT`, 2: SRAM read/write data latency in cycles after the address cycle.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `frame_flag` in 1: one-cycle pulse requesting a buffer swap.
- `vga_flag` in 1: one-cycle read request.
- `vga_hcount` in `LOG_HCOUNT`: pixel column of the request; bit 0 is ignored.
- `vga_vcount` in `LOG_VCOUNT`: line of the request.
- `vga_pixel` out `LOG_MEM`: returned word, held until the next return.
- `done_vga` out 1: one-cycle pulse, `vga_pixel` valid.
- `wr_req` in 1: write request, held high until acked.
- `wr_addr` in `LOG_ADDR`: word offset within the back buffer.
- `wr_data` in `LOG_MEM`: write data.
- `wr_ack` out 1: one-cycle pulse in the cycle the write command is issued.
- `mem_addr` out `LOG_ADDR`: registered SRAM address.
- `mem_we` out 1: registered write enable, active high.
- `mem_dout` out `LOG_MEM`: write data.
- `mem_oe` out 1: high while `mem_dout` must be driven.
- `mem_din` in `LOG_MEM`: read data.
- `front_buf` out 1: buffer currently displayed.

## Operation
**Command slot**
- One memory command is issued per cycle, from the request sampled at the previous edge.
- Priority: a valid VGA read beats a write.
- If no command is issued, the slot is idle: `mem_we`=0 and `mem_addr` holds its previous value.

**VGA read**
- In range means `vga_vcount`<480 and `vga_hcount`<640.
- Read address = front base + `vga_vcount`*320 + `vga_hcount[9:1]`.
- The multiply is implemented as (v<<8)+(v<<6), computed at full `LOG_ADDR` width with no truncation.
- An out-of-range request issues no memory command. It still yields `done_vga` with `vga_pixel`=0 at the same latency, and its slot is given to a pending write.

**Write**
- Write address = back base + `wr_addr`.
- `wr_ack` pulses in the issue cycle.
- `wr_data` is delayed `RD_LAT` cycles onto `mem_dout`, with `mem_oe` high for exactly that one cycle.
- A write stalled by VGA stays pending, with no ack, until a free slot.

**Buffer swap**
- `frame_flag` sets `swap_pending`.
- The swap happens at the first in-range VGA request with `vga_vcount`==0 and `vga_hcount[9:1]`==0 while `swap_pending` is set.
- That request toggles `front_buf` and clears `swap_pending`.
- That request itself reads from the new front buffer.
- Further `frame_flag` pulses while a swap is pending have no effect.
- A `frame_flag` in the same cycle as the swap-point request sets `pending` for the next frame.

**Pipeline**
- Reads are fully pipelined, so back-to-back `vga_flag` pulses are legal.
- Returns come back in request order, one `done_vga` per `vga_flag`.
- A tag pipeline of depth `RD_LAT`+1 marks real vs. zero returns.

## Timing
- `vga_flag` high at edge t → command on `mem_addr` in cycle t+1 → data on `mem_din` in cycle t+1+`RD_LAT` → captured at edge t+2+`RD_LAT`. Therefore `done_vga` and the new `vga_pixel` appear 4 cycles after request with default `RD_LAT`.
- Write: `wr_req` sampled at edge t → `mem_addr`/`mem_we` in cycle t+1 → `wr_ack` also in cycle t+1 → `mem_dout` + `mem_oe` in cycle t+1+`RD_LAT`.
- The client must drop or change `wr_req` the cycle after `wr_ack`. A still-high `wr_req` is a new write.
- Reset values are all 0: `vga_pixel`, `done_vga`, `wr_ack`, `mem_addr`, `mem_we`, `mem_dout`, `mem_oe`, `front_buf`, `swap_pending`, and the tag pipeline.
- Reset mid-operation: in-flight reads are discarded with no `done_vga`, and pending writes are dropped unacked.

## Test plan
- Reset, then `vga_flag` with v=1, h=5 → `mem_addr`=322 at t+1, `mem_we`=0; `mem_din`=36'h123456789 at t+3 → `done_vga` and `vga_pixel`=36'h123456789 at t+4.
- `vga_flag` and `wr_req` (`wr_addr`=7) in the same cycle → read issued first; write issued the next cycle at 19'h40007; `wr_ack` one cycle late; `mem_oe` 2 cycles after that.
- Four back-to-back `vga_flag` with h=0,2,4,6 → addresses 0,1,2,3 on consecutive cycles; four `done_vga` pulses in order with matching data.
- `vga_flag` at v=500 with `wr_req` pending → `done_vga` with `vga_pixel`=0 at latency 4; write issued in that slot.
- Pulse `frame_flag`, then request v=3, then v=0 h=0 → v=3 reads buffer 0; v=0 reads 19'h40000; `front_buf`=1; subsequent writes go to buffer 0.
- Assert `reset` one cycle after `vga_flag` → no `done_vga`; all outputs 0 the next cycle.
